// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS fetch/control types and field constants
package mips_pkg;

    // Fetch stage controller states
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

    // Instruction field positions, shared with mips_control_unit
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

endpackage

// File: rtl/mips_instr_fetch_if.sv
// rtl/mips_instr_fetch_if.sv - Avalon-MM fetch bus plus downstream instruction handshake
// Signals:
//   avm_*            Avalon-MM read master (fetch side is master)
//   instr/opcode/funct/instr_pc/instr_valid/instr_ready  downstream handshake
//   redirect_valid/redirect_target  branch/jump redirect from decode
//   active/fetch_error              run/halt status
interface mips_instr_fetch_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        active;
    logic        fetch_error;

    modport master (
        output avm_address, avm_read, avm_byteenable,
        input  avm_waitrequest, avm_readdata,
        output instr, opcode, funct, instr_pc, instr_valid,
        input  instr_ready, redirect_valid, redirect_target,
        output active, fetch_error
    );

    modport slave (
        input  avm_address, avm_read, avm_byteenable,
        output avm_waitrequest, avm_readdata,
        input  instr, opcode, funct, instr_pc, instr_valid,
        output instr_ready, redirect_valid, redirect_target,
        input  active, fetch_error
    );
endinterface

// File: rtl/mips_pc_sequencer.sv
// rtl/mips_pc_sequencer.sv - pc register, pending delay-slot redirect and next-pc mux
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   transfer_i               held instruction accepted downstream this cycle
//   redirect_valid_i/target_i  accepted instruction is a taken branch/jump
//   pc_o                     current fetch address
//   halt_req_o               delay slot done and redirect target is HALT_ADDR
//   misalign_o               redirect target not word-aligned
module mips_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        transfer_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] pc_o,
    output logic        halt_req_o,
    output logic        misalign_o
);

    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q          <= RESET_VECTOR;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // pc still equals instr_pc while an instruction is held, so pc+4 is
    // the sequential successor of the accepted instruction.
    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        halt_req_o    = 1'b0;
        misalign_o    = 1'b0;
        if (transfer_i) begin
            if (pend_valid_q) begin
                // Delay slot accepted: take the stored target; any redirect
                // arriving with the delay slot is dropped.
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
                halt_req_o   = (pend_target_q == HALT_ADDR);
            end else begin
                pc_d = pc_q + 32'd4;
                if (redirect_valid_i) begin
                    if (redirect_target_i[1:0] != 2'b00) begin
                        misalign_o = 1'b1;
                    end else begin
                        pend_valid_d  = 1'b1;
                        pend_target_d = redirect_target_i;
                    end
                end
            end
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/mips_instr_fetch.sv
// rtl/mips_instr_fetch.sv - MIPS instruction fetch stage: FSM, Avalon read master, instruction buffer
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    mips_instr_fetch_if.master (Avalon fetch, instr handshake, redirect, status)
module mips_instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    mips_instr_fetch_if.master bus
);
    import mips_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;

    logic [31:0]  pc;
    logic         halt_req;
    logic         misalign;
    logic         transfer;
    logic         rd_accept;

    // State resets to FETCH, but the read is gated by reset so it drops the
    // instant reset asserts and rises in the first clock after release.
    assign bus.avm_read       = (state_q == FETCH) && reset;
    assign bus.avm_address    = pc;
    assign bus.avm_byteenable = 4'b1111;

    assign rd_accept = bus.avm_read && !bus.avm_waitrequest;
    assign transfer  = (state_q == HOLD) && valid_q && bus.instr_ready;

    mips_pc_sequencer #(
        .RESET_VECTOR (RESET_VECTOR),
        .HALT_ADDR    (HALT_ADDR)
    ) u_pc_seq (
        .clk               (clk),
        .reset             (reset),
        .transfer_i        (transfer),
        .redirect_valid_i  (bus.redirect_valid),
        .redirect_target_i (bus.redirect_target),
        .pc_o              (pc),
        .halt_req_o        (halt_req),
        .misalign_o        (misalign)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;
        case (state_q)
            FETCH: begin
                if (rd_accept) begin
                    instr_d    = bus.avm_readdata;
                    instr_pc_d = pc;
                    valid_d    = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (transfer) begin
                    valid_d = 1'b0;
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                    end else if (halt_req) begin
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                valid_d = 1'b0;
            end
            default: begin
                valid_d = 1'b0;
                state_d = HALTED;
            end
        endcase
    end

    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
    assign bus.funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.active      = (state_q != HALTED);
    assign bus.fetch_error = err_q;

endmodule

// File: tb/tb_mips_instr_fetch.sv
// tb/tb_mips_instr_fetch.sv - table-driven self-checking bench for mips_instr_fetch
module tb_mips_instr_fetch;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mips_instr_fetch_if bus();

    mips_instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          rst_before;
        logic        wr;
        logic [31:0] rd;
        logic        rdy;
        logic        rv;
        logic [31:0] rt;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_active;
        logic        e_err;
    } vec_t;

    vec_t vq[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s (vec %0d): got %h expected %h", name, idx, act, exp);
        else
            n_pass++;
    endtask

    task automatic add(input bit rb, input logic wr, input logic [31:0] rd, input logic rdy,
                       input logic rv, input logic [31:0] rt, input logic e_read,
                       input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_instr,
                       input logic [31:0] e_pc, input logic e_active, input logic e_err);
        vec_t v;
        v.rst_before = rb; v.wr = wr; v.rd = rd; v.rdy = rdy; v.rv = rv; v.rt = rt;
        v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr;
        v.e_pc = e_pc; v.e_active = e_active; v.e_err = e_err;
        vq.push_back(v);
    endtask

    // Zero-wait fetch of addr returning data, then immediate accept with the given redirect
    task automatic fa(input bit rb, input logic [31:0] addr, input logic [31:0] data,
                      input logic rv, input logic [31:0] rt);
        add(rb, 1'b0, data, 1'b0, 1'b0, 32'h0, 1'b1, addr, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, rv, rt, 1'b0, 32'h0, 1'b1, data, addr, 1'b1, 1'b0);
    endtask

    task automatic halted(input logic err);
        add(1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 32'hBFC0_0400, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, err);
    endtask

    task automatic drive_idle();
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'h0;
        bus.instr_ready     = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
    endtask

    initial begin
        drive_idle();

        // Waitrequest stall on the first fetch, then ready held low
        for (int i = 0; i < 3; i++)
            add(i == 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 32'h2408_0005, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b0, 32'h0BAD_0BAD, 1'b0, 1'b1, 32'hBFC0_0800, 1'b0, 32'h0, 1'b1, 32'h2408_0005, 32'hBFC0_0000, 1'b1, 1'b0);
        add(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h2408_0005, 32'hBFC0_0000, 1'b1, 1'b0);
        // Branch with delay slot; redirect in the delay slot is ignored
        fa(1'b0, 32'hBFC0_0004, 32'h1000_0040, 1'b1, 32'hBFC0_0100);
        fa(1'b0, 32'hBFC0_0008, 32'h0000_0000, 1'b1, 32'hBFC0_0300);
        fa(1'b0, 32'hBFC0_0100, 32'h0128_5020, 1'b0, 32'h0);
        fa(1'b0, 32'hBFC0_0104, 32'h8D09_0004, 1'b0, 32'h0);

        // From reset: sequential run, JR to HALT_ADDR, delay slot, halt
        fa(1'b1, 32'hBFC0_0000, 32'h2408_0005, 1'b0, 32'h0);
        fa(1'b0, 32'hBFC0_0004, 32'h2409_0007, 1'b0, 32'h0);
        fa(1'b0, 32'hBFC0_0008, 32'h0109_5021, 1'b0, 32'h0);
        fa(1'b0, 32'hBFC0_000C, 32'hAD0A_0000, 1'b0, 32'h0);
        fa(1'b0, 32'hBFC0_0010, 32'h0000_0008, 1'b1, 32'h0000_0000);
        fa(1'b0, 32'hBFC0_0014, 32'h0000_0000, 1'b1, 32'hBFC0_0200);
        for (int i = 0; i < 3; i++) halted(1'b0);

        // From reset: misaligned redirect target
        fa(1'b1, 32'hBFC0_0000, 32'h0800_0040, 1'b1, 32'hBFC0_0102);
        for (int i = 0; i < 3; i++) halted(1'b1);

        // Reset state, checked while reset is held
        #1;
        chk("rst_avm_read", -1, {31'h0, bus.avm_read}, 32'h0);
        chk("rst_instr_valid", -1, {31'h0, bus.instr_valid}, 32'h0);
        chk("rst_instr", -1, bus.instr, 32'h0);
        chk("rst_instr_pc", -1, bus.instr_pc, 32'h0);
        chk("rst_active", -1, {31'h0, bus.active}, 32'h1);
        chk("rst_fetch_error", -1, {31'h0, bus.fetch_error}, 32'h0);
        chk("rst_byteenable", -1, {28'h0, bus.avm_byteenable}, 32'hF);

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v;
            v = vq[i];
            if (v.rst_before) begin
                @(negedge clk);
                reset = 1'b0;
                drive_idle();
                @(negedge clk);
                @(negedge clk);
                reset = 1'b1;
            end else begin
                @(negedge clk);
            end
            bus.avm_waitrequest = v.wr;
            bus.avm_readdata    = v.rd;
            bus.instr_ready     = v.rdy;
            bus.redirect_valid  = v.rv;
            bus.redirect_target = v.rt;
            #1;
            chk("avm_read", i, {31'h0, bus.avm_read}, {31'h0, v.e_read});
            if (v.e_read)
                chk("avm_address", i, bus.avm_address, v.e_addr);
            chk("instr_valid", i, {31'h0, bus.instr_valid}, {31'h0, v.e_valid});
            if (v.e_valid) begin
                chk("instr", i, bus.instr, v.e_instr);
                chk("instr_pc", i, bus.instr_pc, v.e_pc);
                chk("opcode", i, {26'h0, bus.opcode}, {26'h0, v.e_instr[31:26]});
                chk("funct", i, {26'h0, bus.funct}, {26'h0, v.e_instr[5:0]});
            end
            chk("active", i, {31'h0, bus.active}, {31'h0, v.e_active});
            chk("fetch_error", i, {31'h0, bus.fetch_error}, {31'h0, v.e_err});
        end

        // Reset asserted in the middle of a waitrequest stall
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        reset = 1'b1;
        bus.avm_waitrequest = 1'b1;
        #1;
        chk("stall_read", 100, {31'h0, bus.avm_read}, 32'h1);
        chk("stall_addr", 100, bus.avm_address, 32'hBFC0_0000);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_read", 101, {31'h0, bus.avm_read}, 32'h0);
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        chk("rst_hold_valid", 102, {31'h0, bus.instr_valid}, 32'h0);
        chk("rst_hold_instr", 102, bus.instr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        bus.avm_readdata = 32'h1111_2222;
        #1;
        chk("restart_read", 103, {31'h0, bus.avm_read}, 32'h1);
        chk("restart_addr", 103, bus.avm_address, 32'hBFC0_0000);
        @(negedge clk);
        #1;
        chk("restart_valid", 104, {31'h0, bus.instr_valid}, 32'h1);
        chk("restart_instr", 104, bus.instr, 32'h1111_2222);
        chk("restart_pc", 104, bus.instr_pc, 32'hBFC0_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
